// File: rtl/latch_load_arbiter.sv
// ---------------------------------------------------------------------------
// latch_load_arbiter
//
// Several requesters share one transparent-latch load port (enable + data).
// A round-robin arbiter picks one requester at a time. Each load then runs
// through a fixed sequence:
//    setup (data stable, enable low)
//    enable window (OPEN_CYC cycles)
//    hold (HOLD_CYC cycles, data still stable)
//    acknowledge (one-cycle pulse)
// This keeps the latch bank and the capture flops behind it from seeing a
// data change near an enable edge.
//
// Ports
//   i_clk   : clock; all state changes on the rising edge
//   i_rst   : synchronous reset, active-high
//   i_req   : per-requester load request (level, held until o_ack)
//   i_data  : requester k data at bits [k*W +: W]
//   o_gnt   : one-hot grant, high for the whole transaction
//   o_ack   : one-cycle completion pulse to the granted requester
//   o_en    : latch enable to the latch bank
//   o_a     : latch data, captured at grant and held for the transaction
//   o_busy  : high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module latch_load_arbiter #(
   parameter int NREQ     = 4,
   parameter int W        = 4,
   parameter int OPEN_CYC = 2,
   parameter int HOLD_CYC = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [NREQ-1:0]   i_req,
   input  logic [NREQ*W-1:0] i_data,
   output logic [NREQ-1:0]   o_gnt,
   output logic [NREQ-1:0]   o_ack,
   output logic              o_en,
   output logic [W-1:0]      o_a,
   output logic              o_busy
);

   localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int MAXC = (OPEN_CYC > HOLD_CYC) ? OPEN_CYC : HOLD_CYC;
   localparam int CW   = (MAXC > 0) ? $clog2(MAXC + 1) : 1;

   // Reload values for the down-counter; the counter reads 0 in the last
   // cycle of its phase.
   localparam logic [CW-1:0]   OPEN_LOAD = CW'(OPEN_CYC - 1);
   localparam logic [CW-1:0]   HOLD_LOAD = (HOLD_CYC > 0) ? CW'(HOLD_CYC - 1) : '0;
   localparam logic [IW-1:0]   LAST_RST  = IW'(NREQ - 1);
   localparam logic [NREQ-1:0] ONE_HOT0  = {{(NREQ-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_OPEN  = 3'd2,
      ST_HOLD  = 3'd3,
      ST_ACK   = 3'd4
   } state_t;

   // Registered state
   state_t            state_r;
   logic [CW-1:0]     cnt_r;
   logic [IW-1:0]     last_r;
   logic [NREQ-1:0]   gnt_r;
   logic [NREQ-1:0]   ack_r;
   logic              en_r;
   logic [W-1:0]      a_r;
   logic              busy_r;

   // Next-state values
   state_t            state_s;
   logic [CW-1:0]     cnt_s;
   logic [IW-1:0]     last_s;
   logic [NREQ-1:0]   gnt_s;
   logic [NREQ-1:0]   ack_s;
   logic              en_s;
   logic [W-1:0]      a_s;
   logic              busy_s;

   // Arbitration result
   logic              win_vld_s;
   logic [IW-1:0]     win_idx_s;
   logic [IW-1:0]     cand_s;
   logic [W-1:0]      win_data_s;

   // Round-robin search: start one past the last grant and wrap, so the
   // previous winner is considered last.
   always_comb begin
      win_vld_s = 1'b0;
      win_idx_s = '0;
      cand_s    = '0;
      for (int i = 1; i <= NREQ; i++) begin
         cand_s = IW'((int'(last_r) + i) % NREQ);
         if (!win_vld_s && i_req[cand_s]) begin
            win_vld_s = 1'b1;
            win_idx_s = cand_s;
         end else begin
            win_vld_s = win_vld_s;
         end
      end
   end

   // Select the data word belonging to the arbitration winner.
   always_comb begin
      win_data_s = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (IW'(k) == win_idx_s) begin
            win_data_s = i_data[k*W +: W];
         end else begin
            win_data_s = win_data_s;
         end
      end
   end

   // Sequencer next-state and next-output logic.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      last_s  = last_r;
      gnt_s   = gnt_r;
      ack_s   = '0;
      en_s    = en_r;
      a_s     = a_r;
      busy_s  = busy_r;

      case (state_r)
         ST_IDLE: begin
            en_s = 1'b0;
            if (win_vld_s) begin
               state_s = ST_SETUP;
               gnt_s   = ONE_HOT0 << win_idx_s;
               a_s     = win_data_s;
               busy_s  = 1'b1;
               last_s  = win_idx_s;
            end else begin
               // Nothing requested: o_a keeps the last loaded value.
               gnt_s  = '0;
               busy_s = 1'b0;
            end
         end

         ST_SETUP: begin
            state_s = ST_OPEN;
            en_s    = 1'b1;
            cnt_s   = OPEN_LOAD;
         end

         ST_OPEN: begin
            if (cnt_r == '0) begin
               en_s = 1'b0;
               if (HOLD_CYC > 0) begin
                  state_s = ST_HOLD;
                  cnt_s   = HOLD_LOAD;
               end else begin
                  // No hold phase: acknowledge straight after the window.
                  state_s = ST_ACK;
                  ack_s   = gnt_r;
               end
            end else begin
               en_s  = 1'b1;
               cnt_s = cnt_r - {{(CW-1){1'b0}}, 1'b1};
            end
         end

         ST_HOLD: begin
            en_s = 1'b0;
            if (cnt_r == '0) begin
               state_s = ST_ACK;
               ack_s   = gnt_r;
            end else begin
               cnt_s = cnt_r - {{(CW-1){1'b0}}, 1'b1};
            end
         end

         ST_ACK: begin
            // ack_s already defaults to zero, so the pulse lasts one cycle.
            state_s = ST_IDLE;
            en_s    = 1'b0;
            gnt_s   = '0;
            busy_s  = 1'b0;
         end

         default: begin
            state_s = ST_IDLE;
            cnt_s   = '0;
            gnt_s   = '0;
            en_s    = 1'b0;
            busy_s  = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_r <= ST_IDLE;
         cnt_r   <= '0;
         last_r  <= LAST_RST;
         gnt_r   <= '0;
         ack_r   <= '0;
         en_r    <= 1'b0;
         a_r     <= '0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         last_r  <= last_s;
         gnt_r   <= gnt_s;
         ack_r   <= ack_s;
         en_r    <= en_s;
         a_r     <= a_s;
         busy_r  <= busy_s;
      end
   end

   assign o_gnt  = gnt_r;
   assign o_ack  = ack_r;
   assign o_en   = en_r;
   assign o_a    = a_r;
   assign o_busy = busy_r;

endmodule

// File: tb/tb_latch_load_arbiter.sv
// ---------------------------------------------------------------------------
// tb_latch_load_arbiter
//
// Self-checking bench for latch_load_arbiter. Instance dut uses the default
// parameters; instance dut_b uses OPEN_CYC=1, HOLD_CYC=0.
//
// Expected grants are pushed to a scoreboard queue when requests are driven.
// A negedge monitor pops one entry per o_ack and compares the acknowledged
// requester, the latched data, and the grant-to-ack latency. It also checks
// the grant/ack/enable invariants on every cycle.
// ---------------------------------------------------------------------------
module tb_latch_load_arbiter;

   localparam int NREQ = 4;
   localparam int W    = 4;

   logic              clk;
   logic              rst;
   logic [NREQ-1:0]   req;
   logic [NREQ*W-1:0] data;
   logic [NREQ-1:0]   gnt;
   logic [NREQ-1:0]   ack;
   logic              en;
   logic [W-1:0]      a;
   logic              busy;

   logic              rst_b;
   logic [NREQ-1:0]   req_b;
   logic [NREQ*W-1:0] data_b;
   logic [NREQ-1:0]   gnt_b;
   logic [NREQ-1:0]   ack_b;
   logic              en_b;
   logic [W-1:0]      a_b;
   logic              busy_b;

   typedef struct {
      logic [NREQ-1:0] ack;
      logic [W-1:0]    a;
   } exp_t;

   exp_t            sb[$];
   int              n_cmp  = 0;
   int              n_err  = 0;
   int              n_ack  = 0;
   int              n_gnt  = 0;
   int              cyc    = 0;
   int              gnt_cyc = 0;
   logic [NREQ-1:0] gnt_prev = '0;

   latch_load_arbiter #(.NREQ(NREQ), .W(W), .OPEN_CYC(2), .HOLD_CYC(1)) dut (
      .i_clk(clk), .i_rst(rst), .i_req(req), .i_data(data),
      .o_gnt(gnt), .o_ack(ack), .o_en(en), .o_a(a), .o_busy(busy)
   );

   latch_load_arbiter #(.NREQ(NREQ), .W(W), .OPEN_CYC(1), .HOLD_CYC(0)) dut_b (
      .i_clk(clk), .i_rst(rst_b), .i_req(req_b), .i_data(data_b),
      .o_gnt(gnt_b), .o_ack(ack_b), .o_en(en_b), .o_a(a_b), .o_busy(busy_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic push_exp(input int idx, input logic [W-1:0] d);
      exp_t e;
      e.ack = 4'b0001 << idx;
      e.a   = d;
      sb.push_back(e);
   endtask

   // Monitor for the default instance: invariants plus scoreboard on o_ack.
   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (!rst) begin
         check_eq("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
         check_eq("ack_in_gnt", 32'(ack & ~gnt), 32'd0);
         check_eq("en_ack_excl", 32'(en && (ack != 4'b0000)), 32'd0);
      end
      if (gnt != 4'b0000 && gnt_prev == 4'b0000) begin
         gnt_cyc = cyc;
         n_gnt++;
      end
      if (ack != 4'b0000) begin
         n_ack++;
         if (sb.size() == 0) begin
            check_eq("sb_unexpected_ack", 32'(ack), 32'd0);
         end else begin
            e = sb.pop_front();
            check_eq("sb_ack", 32'(ack), 32'(e.ack));
            check_eq("sb_data", 32'(a), 32'(e.a));
            check_eq("sb_latency", 32'(cyc - gnt_cyc), 32'd4);
         end
      end
      gnt_prev = gnt;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      int g0;

      // Reset values with every requester asking.
      rst = 1'b1;   req = 4'b1111;   data = 16'hD0B1;
      rst_b = 1'b1; req_b = 4'b0000; data_b = 16'h0007;
      repeat (3) tick();
      check_eq("rst_gnt",  32'(gnt),  32'd0);
      check_eq("rst_ack",  32'(ack),  32'd0);
      check_eq("rst_en",   32'(en),   32'd0);
      check_eq("rst_a",    32'(a),    32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);

      // Round-robin over requesters 0,1,3 held high, starting right out of reset.
      req = 4'b1011;
      push_exp(0, 4'h1); push_exp(1, 4'hB); push_exp(3, 4'hD);
      push_exp(0, 4'h1); push_exp(1, 4'hB); push_exp(3, 4'hD);
      n0 = n_ack;
      g0 = n_gnt;
      rst = 1'b0;
      rst_b = 1'b0;
      tick();
      check_eq("rst_release_gnt", 32'(gnt), 32'h1);
      for (int i = 0; i < 80; i++) begin
         if (n_ack - n0 >= 6) begin
            req = 4'b0000;
            break;
         end
         tick();
      end
      req = 4'b0000;
      check_eq("rr_acks", 32'(n_ack - n0), 32'd6);
      repeat (8) tick();
      check_eq("rr_grants", 32'(n_gnt - g0), 32'd6);

      // Single load from requester 2 with data A.
      data = 16'hDAB1;
      req  = 4'b0100;
      push_exp(2, 4'hA);
      for (int c = 1; c <= 6; c++) begin
         tick();
         if (c == 1) begin
            check_eq("single_gnt", 32'(gnt), 32'h4);
            check_eq("single_a",   32'(a),   32'hA);
         end
         check_eq("single_en",   32'(en),   32'((c == 2) || (c == 3)));
         check_eq("single_ack",  32'(ack),  (c == 5) ? 32'h4 : 32'h0);
         check_eq("single_busy", 32'(busy), 32'(c <= 5));
         if (c == 5) req = 4'b0000;
      end

      // Data change and request drop during OPEN are ignored.
      data = 16'hDA51;
      req  = 4'b0010;
      push_exp(1, 4'h5);
      tick();
      check_eq("stab_gnt", 32'(gnt), 32'h2);
      tick();
      check_eq("stab_en", 32'(en), 32'd1);
      data = 16'hDAF1;
      req  = 4'b0000;
      n0   = n_ack;
      for (int c = 3; c <= 6; c++) begin
         tick();
         check_eq("stab_a", 32'(a), 32'h5);
      end
      check_eq("stab_ack_count", 32'(n_ack - n0), 32'd1);

      // Reset in the middle of OPEN aborts without an acknowledge.
      req = 4'b0100;
      tick();
      check_eq("mid_gnt", 32'(gnt), 32'h4);
      tick();
      check_eq("mid_en", 32'(en), 32'd1);
      rst = 1'b1;
      req = 4'b1111;
      n0  = n_ack;
      tick();
      check_eq("mid_rst_en",   32'(en),   32'd0);
      check_eq("mid_rst_gnt",  32'(gnt),  32'd0);
      check_eq("mid_rst_busy", 32'(busy), 32'd0);
      check_eq("mid_rst_ack",  32'(ack),  32'd0);
      tick();
      push_exp(0, 4'h1);
      rst = 1'b0;
      tick();
      check_eq("mid_prio_gnt", 32'(gnt), 32'h1);
      req = 4'b0000;
      repeat (6) tick();
      check_eq("mid_ack_count", 32'(n_ack - n0), 32'd1);

      // Short configuration: one enable cycle, no hold phase.
      req_b = 4'b0001;
      for (int c = 1; c <= 4; c++) begin
         tick();
         if (c == 1) begin
            check_eq("cfg_gnt", 32'(gnt_b), 32'h1);
            check_eq("cfg_a",   32'(a_b),   32'h7);
            req_b = 4'b0000;
         end
         check_eq("cfg_en",      32'(en_b),   32'(c == 2));
         check_eq("cfg_ack",     32'(ack_b),  (c == 3) ? 32'h1 : 32'h0);
         check_eq("cfg_busy",    32'(busy_b), 32'(c <= 3));
         check_eq("cfg_en_ack",  32'(en_b && (ack_b != 4'b0000)), 32'd0);
         check_eq("cfg_onehot",  32'($countones(gnt_b) <= 1), 32'd1);
      end

      check_eq("sb_drained", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/latch_load_arbiter.md
Name: latch_load_arbiter

Overview:
- Shares one transparent-latch load port (enable + W-bit data) among NREQ requesters.
- Arbitrates round-robin and sequences each load as setup → enable window → hold → acknowledge, so the latch bank and its downstream capture flops see stable data around every enable pulse.
- Sits between requester logic and the latch bank that drives the part-select/flop hierarchy in the top-level wrapper.

Parameters:
- NREQ, 4, number of requesters (≥2).
- W, 4, latch data width.
- OPEN_CYC, 2, cycles o_en is held high per load (≥1).
- HOLD_CYC, 1, cycles data is held after o_en falls (≥0).

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_req  in  NREQ  per-requester load request; level; hold until o_ack.
- i_data  in  NREQ*W  requester k data at bits [k*W +: W].
- o_gnt  out  NREQ  one-hot grant, high for the whole transaction.
- o_ack  out  NREQ  one-cycle completion pulse to the granted requester.
- o_en  out  1  latch enable to the latch bank.
- o_a  out  W  latch data.
- o_busy  out  1  high whenever the FSM is not IDLE.

Behaviour:
- One clock, i_clk. Reset is synchronous and active-high on i_rst.
- All outputs are registered. Reset values: o_gnt=0, o_ack=0, o_en=0, o_a=0, o_busy=0, state=IDLE, counter=0, last_grant=NREQ-1 (so requester 0 has top priority after reset).
- FSM states: IDLE, SETUP, OPEN, HOLD, ACK.
- IDLE:
  - Samples i_req.
  - If nonzero, the winner k is the first set bit scanning from (last_grant+1) mod NREQ upward with wrap.
  - Next edge: state=SETUP, o_gnt=1<<k, o_a=i_data[k], o_busy=1, last_grant=k.
  - If i_req is zero, the FSM stays in IDLE and o_a keeps its previous value.
- SETUP: lasts 1 cycle with o_en=0. Next edge: state=OPEN, o_en=1, counter=OPEN_CYC-1.
- OPEN:
  - o_en stays high for exactly OPEN_CYC cycles.
  - When counter=0: if HOLD_CYC>0, go to HOLD with o_en=0 and counter=HOLD_CYC-1; otherwise go to ACK with o_en=0.
- HOLD: o_en=0 and o_a is unchanged. When counter=0, go to ACK.
- ACK:
  - o_ack[k]=1 for exactly one cycle; o_gnt is still held.
  - Next edge: state=IDLE, o_gnt=0, o_ack=0, o_busy=0.
- Latency:
  - Request sampled at edge T gives o_en high during cycles T+2 .. T+1+OPEN_CYC.
  - o_ack is high during cycle T+2+OPEN_CYC+HOLD_CYC.
  - Defaults: o_en high in cycles 2–3, o_ack high in cycle 5, next arbitration at edge T+5.
- o_a is captured once at grant and held constant through SETUP/OPEN/HOLD/ACK. Changes on i_data during a transaction are ignored.
- If i_req[k] drops mid-transaction, the transaction still completes and o_ack[k] still pulses. No abort exists.
- A requester that keeps i_req high through ACK is re-arbitrated in the following IDLE cycle as a new request. Round-robin then favours the other requesters; a lone requester is granted again.
- If i_req rises while busy, it is only sampled in IDLE. No request is lost, because requests are levels.
- Invariants:
  - At most one bit of o_gnt is set; o_ack ⊆ o_gnt.
  - o_en=1 implies state=OPEN.
  - o_en is never high in the same cycle as o_ack, nor in SETUP.
- Reset mid-transaction (any state): the next edge forces all reset values, so o_en falls immediately and no o_ack is issued.
- Counter width is clog2(max(OPEN_CYC,HOLD_CYC)+1). It counts down only and never wraps.

Test Plan:
- Reset values: hold i_rst=1 for 3 cycles with i_req=4'b1111 → all outputs 0 and no grant. Release → o_gnt=4'b0001 one edge later.
- Single load: i_req=4'b0100, i_data[11:8]=4'hA, defaults → o_a=4'hA from cycle 1, o_en=1 in cycles 2–3 only, o_ack=4'b0100 in cycle 5 only, o_busy falls at cycle 6.
- Round-robin: i_req=4'b1011 held high throughout → grant order 0,1,3,0,1,3, each with o_ack after 5 cycles and exactly one o_ack per grant.
- Stability: during OPEN, change i_data for the granted requester 5→F and drop its i_req → o_a stays 5 and o_ack still pulses.
- Reset mid-OPEN: assert i_rst in cycle 2 → o_en=0, o_gnt=0, o_busy=0 at the next edge, and no o_ack. After release, requester 0 has priority again.
- Config: OPEN_CYC=1, HOLD_CYC=0, i_req=4'b0001 → o_en high in cycle 2 only, o_ack in cycle 3. Check the one-hot and o_en/o_ack exclusivity assertions hold in every run.
